// File: rtl/audio_sample_pacer.sv
// Paces 16-bit samples from the flash reader to the audio codec at a runtime-adjustable rate.
// Owns the sample-rate divider, speed control, pause, and overrun detection.
module audio_sample_pacer #(
    parameter int unsigned DEFAULT_PERIOD = 2272,
    parameter int unsigned MIN_PERIOD     = 1136,
    parameter int unsigned MAX_PERIOD     = 4544,
    parameter int unsigned STEP           = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] passdata,
    input  logic        speed_up,
    input  logic        speed_down,
    input  logic        speed_reset,
    input  logic        pause,
    input  logic        audio_ready,
    input  logic        overrun_clr,
    output logic        confirm_reciv,
    output logic [15:0] audio_data,
    output logic        audio_write,
    output logic        overrun,
    output logic [15:0] period,
    output logic        state_dbg
);

    localparam logic [16:0] DEF17  = 17'(DEFAULT_PERIOD);
    localparam logic [16:0] MIN17  = 17'(MIN_PERIOD);
    localparam logic [16:0] MAX17  = 17'(MAX_PERIOD);
    localparam logic [16:0] STEP17 = 17'(STEP);

    typedef enum logic {
        WAIT_TICK = 1'b0,
        WRITE     = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [15:0] cnt;
    logic        tick;
    logic        wrap;
    logic [16:0] p_dec, p_inc, period_next;
    logic [15:0] data_next;
    logic        write_next, confirm_next, overrun_next;

    assign state_dbg = (state == WRITE);

    // Divider: >= so that a shortened period still wraps a counter already past it.
    assign wrap = {1'b0, cnt} >= ({1'b0, period} - 17'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= 16'd0;
            tick <= 1'b0;
        end else if (pause) begin
            tick <= 1'b0;
        end else if (wrap) begin
            cnt  <= 16'd0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 16'd1;
            tick <= 1'b0;
        end
    end

    // 17-bit arithmetic; bit 16 of p_dec flags a borrow below zero.
    always_comb begin
        p_dec       = {1'b0, period} - STEP17;
        p_inc       = {1'b0, period} + STEP17;
        period_next = {1'b0, period};
        if (speed_reset) begin
            period_next = DEF17;
        end else if (speed_up && speed_down) begin
            period_next = {1'b0, period};
        end else if (speed_up) begin
            period_next = (p_dec[16] || (p_dec < MIN17)) ? MIN17 : p_dec;
        end else if (speed_down) begin
            period_next = (p_inc > MAX17) ? MAX17 : p_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period <= DEF17[15:0];
        end else begin
            period <= period_next[15:0];
        end
    end

    // audio_write/audio_ready form a valid/ready pair: a write transfers on any edge
    // where both are high, and audio_write with audio_data stays stable until then.
    always_comb begin
        state_next   = state;
        data_next    = audio_data;
        write_next   = audio_write;
        confirm_next = 1'b0;
        overrun_next = overrun_clr ? 1'b0 : overrun;
        case (state)
            WAIT_TICK: begin
                if (tick) begin
                    data_next    = passdata;
                    confirm_next = 1'b1;
                    write_next   = 1'b1;
                    state_next   = WRITE;
                end
            end
            WRITE: begin
                write_next = 1'b1;
                if (audio_ready) begin
                    write_next = 1'b0;
                    state_next = WAIT_TICK;
                end
                if (tick) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = WAIT_TICK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= WAIT_TICK;
            audio_data    <= 16'd0;
            audio_write   <= 1'b0;
            confirm_reciv <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            audio_data    <= data_next;
            audio_write   <= write_next;
            confirm_reciv <= confirm_next;
            overrun       <= overrun_next;
        end
    end

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer with small periods (default 8, min 4, max 12, step 4).
// Expected latencies and periods below are hand-derived from the cycle timing.
module tb_audio_sample_pacer;

    localparam int unsigned DEF  = 8;
    localparam int unsigned MINP = 4;
    localparam int unsigned MAXP = 12;
    localparam int unsigned STP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] passdata;
    logic        speed_up, speed_down, speed_reset, pause, audio_ready, overrun_clr;
    logic        confirm_reciv, audio_write, overrun, state_dbg;
    logic [15:0] audio_data, period;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'd0;
    int          n;
    int          nconf;

    audio_sample_pacer #(
        .DEFAULT_PERIOD(DEF),
        .MIN_PERIOD    (MINP),
        .MAX_PERIOD    (MAXP),
        .STEP          (STP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .passdata     (passdata),
        .speed_up     (speed_up),
        .speed_down   (speed_down),
        .speed_reset  (speed_reset),
        .pause        (pause),
        .audio_ready  (audio_ready),
        .overrun_clr  (overrun_clr),
        .confirm_reciv(confirm_reciv),
        .audio_data   (audio_data),
        .audio_write  (audio_write),
        .overrun      (overrun),
        .period       (period),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic dn, input logic rs);
        speed_up    = up;
        speed_down  = dn;
        speed_reset = rs;
        step();
        speed_up    = 1'b0;
        speed_down  = 1'b0;
        speed_reset = 1'b0;
    endtask

    // Returns the number of edges until confirm_reciv is seen, bounded by max.
    task automatic wait_confirm(input int max, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!confirm_reciv && cycles < max);
        check("confirm_seen", 32'(confirm_reciv), 32'd1);
        if (confirm_reciv) begin
            if (exp_q.size() > 0) last_exp = exp_q.pop_front();
            check("sample", 32'(audio_data), 32'(last_exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; passdata = 16'h1234; speed_up = 1'b0; speed_down = 1'b0;
        speed_reset = 1'b0; pause = 1'b0; audio_ready = 1'b1; overrun_clr = 1'b0;
        exp_q.push_back(16'h1234);
        repeat (3) step();
        check("rst_write",   32'(audio_write),   32'd0);
        check("rst_confirm", 32'(confirm_reciv), 32'd0);
        check("rst_overrun", 32'(overrun),       32'd0);
        check("rst_data",    32'(audio_data),    32'd0);
        check("rst_period",  32'(period),        32'(DEF));
        check("rst_state",   32'(state_dbg),     32'd0);
        rst = 1'b0;

        // Nominal pacing
        wait_confirm(20, n);
        check("first_latency", 32'(n), 32'd9);
        check("write_on_tick", 32'(audio_write), 32'd1);
        check("state_write",   32'(state_dbg),   32'd1);
        step();
        check("write_one_cycle", 32'(audio_write),   32'd0);
        check("confirm_width",   32'(confirm_reciv), 32'd0);
        wait_confirm(20, n);
        check("nominal_gap_a", 32'(n), 32'd7);
        wait_confirm(20, n);
        check("nominal_gap_b", 32'(n), 32'd8);

        // Backpressure: ready low for three sampled edges
        audio_ready = 1'b0;
        passdata = 16'hbeef;
        exp_q.push_back(16'hbeef);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_write_held",  32'(audio_write), 32'd1);
            check("bp_data_stable", 32'(audio_data),  32'h1234);
        end
        audio_ready = 1'b1;
        step();
        check("bp_write_release", 32'(audio_write), 32'd0);
        check("bp_no_overrun",    32'(overrun),     32'd0);
        wait_confirm(20, n);
        check("bp_next_tick", 32'(n), 32'd4);

        // Overrun: two ticks land in a stalled write
        audio_ready = 1'b0;
        nconf = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (confirm_reciv) nconf++;
        end
        check("ovr_confirms",   32'(nconf),       32'd0);
        check("ovr_set",        32'(overrun),     32'd1);
        check("ovr_write_held", 32'(audio_write), 32'd1);
        check("ovr_data",       32'(audio_data),  32'hbeef);
        audio_ready = 1'b1;
        step();
        check("ovr_write_done", 32'(audio_write), 32'd0);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Clamping
        repeat (3) pulse(1'b1, 1'b0, 1'b0);
        check("clamp_min", 32'(period), 32'(MINP));
        repeat (5) pulse(1'b0, 1'b1, 1'b0);
        check("clamp_max", 32'(period), 32'(MAXP));
        pulse(1'b1, 1'b1, 1'b0);
        check("up_down_hold", 32'(period), 32'(MAXP));
        pulse(1'b1, 1'b0, 1'b1);
        check("reset_wins", 32'(period), 32'(DEF));
        pulse(1'b0, 1'b1, 1'b0);
        check("step_down", 32'd12, 32'(period));

        // Shorten mid-count: speed_up sampled with cnt=7, period 12 -> 8
        wait_confirm(30, n);
        wait_confirm(30, n);
        check("period_12_gap", 32'(n), 32'd12);
        repeat (6) step();
        pulse(1'b1, 1'b0, 1'b0);
        check("shorten_period", 32'(period), 32'd8);
        wait_confirm(30, n);
        check("shorten_tick", 32'(n), 32'd2);
        wait_confirm(30, n);
        check("shorten_wrap", 32'(n), 32'd8);

        // Pause freezes cnt at 1; resume needs 8 edges to the next confirm
        pause = 1'b1;
        nconf = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (confirm_reciv) nconf++;
        end
        pause = 1'b0;
        check("pause_confirms", 32'(nconf), 32'd0);
        wait_confirm(30, n);
        check("pause_frozen", 32'(n), 32'd8);

        // Reset in the middle of a stalled write
        pulse(1'b0, 1'b1, 1'b0);
        audio_ready = 1'b0;
        wait_confirm(30, n);
        check("pre_rst_write", 32'(audio_write), 32'd1);
        repeat (12) step();
        check("pre_rst_overrun", 32'(overrun), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_write",   32'(audio_write),   32'd0);
        check("mid_rst_confirm", 32'(confirm_reciv), 32'd0);
        check("mid_rst_data",    32'(audio_data),    32'd0);
        check("mid_rst_overrun", 32'(overrun),       32'd0);
        check("mid_rst_period",  32'(period),        32'(DEF));
        check("mid_rst_state",   32'(state_dbg),     32'd0);
        rst = 1'b0;
        audio_ready = 1'b1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
